// File: rtl/ser_sum_collect.sv
// ser_sum_collect: operand handoff and LSB-first result collection around an external serial adder
module ser_sum_collect #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             mode,
  input  logic             sum_in,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             busy
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic accept;
  // op_ready is low for the first cycle after reset, so nothing is accepted on that edge
  always_comb begin
    accept = state == IDLE && op_ready && op_valid;
    nxt = state == IDLE  ? (accept ? LOAD : IDLE) :
          state == LOAD  ? SHIFT :
          state == SHIFT ? (cnt == CW'(WIDTH - 1) ? DONE : SHIFT) :
                           (result_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      result       <= '0;
      op_a         <= '0;
      op_b         <= '0;
      op_ready     <= 1'b0;
      mode         <= 1'b0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= nxt;
      op_ready     <= nxt == IDLE;
      mode         <= nxt == LOAD;
      result_valid <= nxt == DONE;
      busy         <= nxt != IDLE;
      if (accept) begin
        op_a <= a_in;
        op_b <= b_in;
      end
      if (state == LOAD) cnt <= '0;
      if (state == SHIFT) begin
        result <= {sum_in, result[WIDTH-1:1]};
        cnt    <= cnt + 1'b1;
      end
    end
  end
endmodule
